// File: rtl/gate_sched_pkg.sv
// Shared definitions for the round-robin gate scheduler: opcodes and FSM states.
package gate_sched_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/gate_rr_scheduler_gate_unit.sv
// Registered bitwise logic unit; result updates only when enabled.
module gate_unit
  import gate_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] y_c;

  always_comb begin
    y_c = a & b;
    case (op)
      OP_AND:  y_c = a & b;
      OP_OR:   y_c = a | b;
      OP_XOR:  y_c = a ^ b;
      OP_NAND: y_c = ~(a & b);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (en) begin
      y <= y_c;
    end
  end

endmodule

// File: rtl/gate_rr_scheduler.sv
// Round-robin scheduler sharing one registered gate unit among NUM_REQ requesters.
module gate_rr_scheduler
  import gate_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned WIDTH   = 8,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  // Returns {found, index} of the first valid requester at or after base, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [IDW-1:0]     base);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    logic           found;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((32'(base) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        found = 1'b1;
        res   = {1'b1, idx};
      end
    end
    return res;
  endfunction

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     ptr_inc;
  logic               any_valid;
  logic               hs;
  logic               unit_en;
  logic [NUM_REQ-1:0] grant_c;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         op_q;

  always_comb begin
    {any_valid, winner} = rr_pick(req_valid, ptr_q);
    ptr_inc = IDW'((32'(winner) + 32'd1) % NUM_REQ);
  end

  always_comb begin
    state_d = state_q;
    grant_c = '0;
    hs      = 1'b0;
    unit_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          grant_c[winner] = 1'b1;
          hs              = 1'b1;
          state_d         = S_EXEC;
        end
      end
      S_EXEC: begin
        unit_en = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grants are suppressed while reset is held so nothing is accepted before release.
  assign req_ready = grant_c & {NUM_REQ{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      rsp_id    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= (state_d == S_RESP);
      busy      <= (state_d != S_IDLE);
      if (hs) begin
        ptr_q  <= ptr_inc;
        rsp_id <= winner;
        a_q    <= req_a[32'(winner)*WIDTH +: WIDTH];
        b_q    <= req_b[32'(winner)*WIDTH +: WIDTH];
        op_q   <= req_op[32'(winner)*2 +: 2];
      end
    end
  end

  gate_unit #(.WIDTH(WIDTH)) u_gate (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (unit_en),
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .y     (rsp_data)
  );

endmodule
